// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction-fetch stage: PC, imem requests, 1-entry skid buffer, IF/ID register.
// Optional macro IF_MISALIGN_CHK_EN adds misalign_o and halts fetch on a misaligned redirect target.
module if_stage #(
   parameter int unsigned       AWIDTH   = 32,
   parameter int unsigned       DWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
   parameter logic [DWIDTH-1:0] NOP_INSN = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   output logic              imem_req_o,
   output logic [AWIDTH-1:0] imem_addr_o,
   input  logic [DWIDTH-1:0] imem_rdata_i,
   output logic              if_valid_o,
   output logic [AWIDTH-1:0] if_pc_o,
   output logic [DWIDTH-1:0] if_insn_o
`ifdef IF_MISALIGN_CHK_EN
   ,
   output logic              misalign_o
`endif
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HOLD = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic              pend_q, pend_d;
   logic [AWIDTH-1:0] pend_pc_q, pend_pc_d;
   logic              skid_v_q, skid_v_d;
   logic [AWIDTH-1:0] skid_pc_q, skid_pc_d;
   logic [DWIDTH-1:0] skid_insn_q, skid_insn_d;
   logic              if_valid_q, if_valid_d;
   logic [AWIDTH-1:0] if_pc_q, if_pc_d;
   logic [DWIDTH-1:0] if_insn_q, if_insn_d;
   logic [AWIDTH-1:0] target;
   logic              halted;

`ifdef IF_MISALIGN_CHK_EN
   logic misalign_q;
   logic redirect_bad;

   assign target       = redirect_pc_i;
   assign redirect_bad = redirect_i & (redirect_pc_i[1:0] != 2'b00);
   // The offending redirect cycle already counts as halted so the bad target is never fetched.
   assign halted       = misalign_q | redirect_bad;
   assign misalign_o   = misalign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_q | redirect_bad;
      end
   end
`else
   assign target = {redirect_pc_i[AWIDTH-1:2], 2'b00};
   assign halted = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = 1'b0;
      pend_pc_d   = pend_pc_q;
      skid_v_d    = skid_v_q;
      skid_pc_d   = skid_pc_q;
      skid_insn_d = skid_insn_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_insn_d   = if_insn_q;

      imem_req_o  = !rst && !halted && (!stall_i || redirect_i);
      imem_addr_o = redirect_i ? target : pc_q;

      if (imem_req_o) begin
         pc_d      = imem_addr_o + AWIDTH'(4);
         pend_d    = 1'b1;
         pend_pc_d = imem_addr_o;
      end

      // A redirect (or halt) drops the in-flight response and any skid contents.
      if (halted || redirect_i) begin
         state_d    = S_RUN;
         skid_v_d   = 1'b0;
         if_valid_d = 1'b0;
         if_insn_d  = NOP_INSN;
      end else begin
         case (state_q)
            S_RUN: begin
               if (pend_q) begin
                  if (stall_i) begin
                     skid_v_d    = 1'b1;
                     skid_pc_d   = pend_pc_q;
                     skid_insn_d = imem_rdata_i;
                     state_d     = S_HOLD;
                  end else begin
                     if_valid_d = 1'b1;
                     if_pc_d    = pend_pc_q;
                     if_insn_d  = imem_rdata_i;
                  end
               end else if (!stall_i) begin
                  if_valid_d = 1'b0;
                  if_insn_d  = NOP_INSN;
               end
            end
            S_HOLD: begin
               if (!stall_i) begin
                  if_valid_d = skid_v_q;
                  if_pc_d    = skid_pc_q;
                  if_insn_d  = skid_insn_q;
                  skid_v_d   = 1'b0;
                  state_d    = S_RUN;
               end
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RUN;
         pc_q        <= BASEADDR;
         pend_q      <= 1'b0;
         pend_pc_q   <= '0;
         skid_v_q    <= 1'b0;
         skid_pc_q   <= '0;
         skid_insn_q <= NOP_INSN;
         if_valid_q  <= 1'b0;
         if_pc_q     <= '0;
         if_insn_q   <= NOP_INSN;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         pend_pc_q   <= pend_pc_d;
         skid_v_q    <= skid_v_d;
         skid_pc_q   <= skid_pc_d;
         skid_insn_q <= skid_insn_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_insn_q   <= if_insn_d;
      end
   end

   assign if_valid_o = if_valid_q;
   assign if_pc_o    = if_pc_q;
   assign if_insn_o  = if_insn_q;

endmodule
